// File: rtl/truth_table_sweeper.sv
// Steps a 4-input circuit through all 16 input vectors, samples its synchronized
// output at the end of each settle window and scores it against TRUTH_TABLE.
module truth_table_sweeper #(
  parameter logic [15:0] TRUTH_TABLE   = 16'h2C26,
  parameter int          SETTLE_CYCLES = 4,
  parameter int          SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [3:0]  dut_in,
  input  logic        dut_out,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic        pass,
  output logic [15:0] mismatch_mask,
  output logic [4:0]  fail_count
);

  if (SETTLE_CYCLES < SYNC_STAGES + 1 || SETTLE_CYCLES > 255 ||
      SYNC_STAGES < 1 || SYNC_STAGES > 3) begin : g_param_check
    $error("truth_table_sweeper: SETTLE_CYCLES/SYNC_STAGES out of range");
  end

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [3:0]             vec_q, vec_d;
  logic [15:0]            mask_q, mask_d;
  logic [4:0]             fcnt_q, fcnt_d;
  logic                   pass_q, pass_d;
  logic                   abrt_q, abrt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   miss;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      mask_q  <= '0;
      fcnt_q  <= '0;
      pass_q  <= 1'b0;
      abrt_q  <= 1'b0;
      sync_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vec_q     <= vec_d;
      mask_q    <= mask_d;
      fcnt_q    <= fcnt_d;
      pass_q    <= pass_d;
      abrt_q    <= abrt_d;
      sync_q[0] <= dut_out;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign miss = sync_q[SYNC_STAGES-1] ^ TRUTH_TABLE[vec_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    mask_d  = mask_q;
    fcnt_d  = fcnt_q;
    pass_d  = pass_q;
    abrt_d  = abrt_q;
    unique case (state_q)
      IDLE: begin
        // start has priority over a coincident abort
        if (start) begin
          state_d = SETTLE;
          cnt_d   = '0;
          vec_d   = '0;
          mask_d  = '0;
          fcnt_d  = '0;
          pass_d  = 1'b0;
          abrt_d  = 1'b0;
        end
      end
      SETTLE: begin
        // abort discards a sample landing in the same cycle
        if (abort) begin
          state_d = IDLE;
          abrt_d  = 1'b1;
        end else if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (miss) begin
            mask_d[vec_q] = 1'b1;
            fcnt_d        = fcnt_q + 5'd1;
          end
          if (vec_q == 4'd15) begin
            state_d = DONE;
            pass_d  = (fcnt_d == 5'd0);
          end else begin
            vec_d = vec_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign dut_in        = vec_q;
  assign busy          = (state_q == SETTLE);
  assign done          = (state_q == DONE);
  assign aborted       = abrt_q;
  assign pass          = pass_q;
  assign mismatch_mask = mask_q;
  assign fail_count    = fcnt_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench: behavioural circuit models feed two sweepers (settle 4 and 6); results
// are queued when a sweep is launched and scored when done pulses.
module tb_truth_table_sweeper;
  localparam logic [15:0] TT = 16'h2C26;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic start6 = 1'b0, abort6 = 1'b0;
  logic [3:0] dut_in, dut_in6;
  logic dut_out, dut_out6;
  logic busy, done, aborted, pass, busy6, done6, aborted6, pass6;
  logic [15:0] mismatch_mask, mismatch_mask6;
  logic [4:0] fail_count, fail_count6;
  logic [15:0] tt_v;
  logic [3:0] d1 = '0, d2 = '0, d3 = '0, e1 = '0, e2 = '0, e3 = '0;
  int mode = 0; // 0 ideal, 1 stuck-at-0, 2 inverted, 3 late by 3 cycles
  int total = 0, bad = 0;

  typedef struct {logic [15:0] mask; logic [4:0] cnt; logic pass;} res_t;
  typedef struct {int mode; logic [15:0] mask; logic [4:0] cnt; logic pass;} vec_t;
  res_t q[$], q6[$];
  vec_t tbl[3];

  always #5 clk = ~clk;
  assign tt_v = TT;

  truth_table_sweeper #(.TRUTH_TABLE(TT), .SETTLE_CYCLES(4), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_in(dut_in),
    .dut_out(dut_out), .busy(busy), .done(done), .aborted(aborted), .pass(pass),
    .mismatch_mask(mismatch_mask), .fail_count(fail_count));

  truth_table_sweeper #(.TRUTH_TABLE(TT), .SETTLE_CYCLES(6), .SYNC_STAGES(2)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .start(start6), .abort(abort6), .dut_in(dut_in6),
    .dut_out(dut_out6), .busy(busy6), .done(done6), .aborted(aborted6), .pass(pass6),
    .mismatch_mask(mismatch_mask6), .fail_count(fail_count6));

  // late model: response follows the input through three register delays
  always @(posedge clk) begin
    d1 <= dut_in;  d2 <= d1; d3 <= d2;
    e1 <= dut_in6; e2 <= e1; e3 <= e2;
  end

  always_comb begin
    dut_out = 1'b0;
    case (mode)
      0:       dut_out = tt_v[dut_in];
      1:       dut_out = 1'b0;
      2:       dut_out = ~tt_v[dut_in];
      default: dut_out = tt_v[d3];
    endcase
  end
  assign dut_out6 = tt_v[e3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (done === 1'b1) begin
      res_t r;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL done: got unexpected done pulse expected none");
      end else begin
        r = q.pop_front();
        chk("mask", mismatch_mask, r.mask);
        chk("fail_count", fail_count, r.cnt);
        chk("pass", pass, r.pass);
      end
    end
    if (done6 === 1'b1) begin
      res_t r;
      total++;
      if (q6.size() == 0) begin
        bad++;
        $display("FAIL done6: got unexpected done pulse expected none");
      end else begin
        r = q6.pop_front();
        chk("mask6", mismatch_mask6, r.mask);
        chk("fail_count6", fail_count6, r.cnt);
        chk("pass6", pass6, r.pass);
      end
    end
  end

  task automatic go(input bit ab);
    start = 1'b1; abort = ab;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("busy after start", busy, 1);
    chk("dut_in after start", dut_in, 0);
    chk("aborted cleared", aborted, 0);
    chk("mask cleared", mismatch_mask, 0);
    chk("count cleared", fail_count, 0);
    chk("pass cleared", pass, 0);
  endtask

  task automatic wait_done(input bit steps, input bit restart, output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 300) begin
      start = restart && (lat == 10 || lat == 40 || lat == 64);
      tick();
      start = 1'b0;
      lat++;
      if (steps && lat % 4 == 3 && lat < 64) chk("dut_in step", dut_in, (lat - 1) / 4);
    end
    if (lat >= 300) chk("done timeout", done, 1);
  endtask

  task automatic abort_at(input int n);
    int lat;
    mode = 1;
    go(0);
    lat = 1;
    while (lat < n) begin tick(); lat++; end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("busy after abort", busy, 0);
    chk("aborted set", aborted, 1);
    chk("partial mask", mismatch_mask, tt_v & 16'h001F);
    chk("partial count", fail_count, $countones(tt_v & 16'h001F));
    chk("pass after abort", pass, 0);
    chk("dut_in held", dut_in, 5);
    repeat (70) tick();
    chk("aborted sticky", aborted, 1);
  endtask

  initial begin
    int lat;
    tbl[0] = '{0, 16'h0000, 5'd0, 1'b1};
    tbl[1] = '{1, TT, 5'($countones(TT)), 1'b0};
    tbl[2] = '{2, 16'hFFFF, 5'd16, 1'b0};

    repeat (3) tick();
    chk("rst dut_in", dut_in, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst aborted", aborted, 0);
    chk("rst pass", pass, 0);
    chk("rst mask", mismatch_mask, 0);
    chk("rst count", fail_count, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 3; i++) begin
      mode = tbl[i].mode;
      repeat (4) tick();
      q.push_back('{tbl[i].mask, tbl[i].cnt, tbl[i].pass});
      go(0);
      wait_done(1, 0, lat);
      chk("done latency", lat, 65);
      tick();
      chk("done one cycle", done, 0);
      chk("busy after done", busy, 0);
      chk("dut_in after done", dut_in, 15);
    end

    abort_at(22);
    abort_at(24);

    // start and abort together in IDLE: start wins, aborted cleared in go()
    q.push_back('{TT, 5'($countones(TT)), 1'b0});
    go(1);
    wait_done(0, 0, lat);
    chk("start+abort latency", lat, 65);

    // repeated start while busy and during DONE are ignored
    mode = 0;
    tick();
    q.push_back('{16'h0000, 5'd0, 1'b1});
    go(0);
    wait_done(0, 1, lat);
    chk("restart latency", lat, 65);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start in DONE ignored", busy, 0);
    chk("pass holds", pass, 1);

    // asynchronous reset mid-sweep
    mode = 1;
    go(0);
    repeat (19) tick();
    chk("mask before reset", mismatch_mask, tt_v & 16'h000F);
    rst_n = 1'b0;
    #1;
    chk("mid rst busy", busy, 0);
    chk("mid rst dut_in", dut_in, 0);
    chk("mid rst mask", mismatch_mask, 0);
    chk("mid rst count", fail_count, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (80) tick();
    chk("no done after reset", busy, 0);

    // late-settling circuit: settle 4 catches the previous vector, settle 6 passes
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mode = 3;
    repeat (6) tick();
    q.push_back('{(tt_v ^ {tt_v[14:0], 1'b0}) & 16'hFFFE,
                  5'($countones((tt_v ^ {tt_v[14:0], 1'b0}) & 16'hFFFE)), 1'b0});
    q6.push_back('{16'h0000, 5'd0, 1'b1});
    start = 1'b1; start6 = 1'b1;
    tick();
    start = 1'b0; start6 = 1'b0;
    lat = 1;
    while (done6 !== 1'b1 && lat < 300) begin tick(); lat++; end
    chk("settle6 latency", lat, 97);
    repeat (3) tick();
    chk("scoreboard drained", q.size() + q6.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
endmodule
